// File: rtl/cla_seq_adder.sv
// Serial carry-look-ahead adder: adds two W=4*NIBBLES operands one nibble per
// cycle through a single 4-bit CLA slice. Define CLA_SEQ_SUB_EN to add a `sub` port (a-b mode).

module carry_look_ahead_gen (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       carry
);
  logic [3:0] p;
  logic [3:0] g;
  logic [4:0] c;

  assign p = a ^ b;
  assign g = a & b;

  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);

  assign sum   = p ^ c[3:0];
  assign carry = c[4];
endmodule

// Handshakes: a request moves on a rising edge with in_valid && in_ready, a
// result moves on a rising edge with res_valid && res_ready; valid never waits on ready.
module cla_seq_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  input  logic                   cin,
`ifdef CLA_SEQ_SUB_EN
  input  logic                   sub,
`endif
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [4*NIBBLES-1:0]   sum,
  output logic                   cout,
  output logic                   busy,
  output logic [1:0]             dbg_state
);
  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic            carry_q;
  logic [IW-1:0]   idx;
  logic [W-1:0]    sum_q;
  logic            cout_q;
  logic            accept;
  logic            last;
  logic            sub_mode;
  logic [3:0]      cla_sum;
  logic            cla_carry;

`ifdef CLA_SEQ_SUB_EN
  assign sub_mode = sub;
`else
  assign sub_mode = 1'b0;
`endif

  // in_ready is gated by rst_n so it reads low for the whole reset window.
  assign in_ready  = (state == IDLE) && rst_n;
  assign res_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign dbg_state = state;
  assign sum       = sum_q;
  assign cout      = cout_q;

  assign accept = in_valid && in_ready;
  assign last   = (idx == IW'(NIBBLES - 1));

  carry_look_ahead_gen u_cla (
    a_q[{idx, 2'b00} +: 4],
    b_q[{idx, 2'b00} +: 4],
    carry_q,
    cla_sum,
    cla_carry
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            a_q     <= a;
            // Subtraction is a + ~b + 1: invert b once here and seed the carry.
            b_q     <= sub_mode ? ~b : b;
            carry_q <= sub_mode ? 1'b1 : cin;
            idx     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
          end
        end
        RUN: begin
          sum_q[{idx, 2'b00} +: 4] <= cla_sum;
          carry_q                  <= cla_carry;
          idx                      <= idx + IW'(1);
          if (last) cout_q <= cla_carry;
        end
        default: begin
        end
      endcase
    end
  end
endmodule

// File: doc/cla_seq_adder.md
CLA_SEQ_ADDER -- requirements
Module: cla_seq_adder

Interface
REQ-001 Parameter NIBBLES, default 4, SHALL set the number of 4-bit slices per operand; operand width W = 4*NIBBLES, legal range 2..16.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 in_valid  input  1  SHALL mark that a, b and cin (and sub, if compiled in) hold a request.
REQ-005 in_ready  output  1  SHALL be high only when the block can accept a request.
REQ-006 a, b  input  W each  SHALL be the addend operands.
REQ-007 cin  input  1  SHALL be the carry-in to the least significant nibble.
REQ-008 res_valid  output  1  SHALL mark that sum and cout hold a completed result.
REQ-009 res_ready  input  1  SHALL mark that the consumer takes the result.
REQ-010 sum  output  W  SHALL be the result.
REQ-011 cout  output  1  SHALL be the carry out of the top nibble.
REQ-012 busy  output  1  SHALL be high whenever the state is not IDLE.

Function
REQ-013 The block SHALL compute a+b+cin serially, one nibble per cycle, through one instance of carry_look_ahead_gen using port order (a, b, cin, sum, carry).
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-015 In IDLE, in_ready SHALL be 1; in RUN and DONE, in_ready SHALL be 0.
REQ-016 Handshake: a request SHALL be accepted on a rising edge where in_valid && in_ready.
REQ-017 On acceptance, the block SHALL latch the operands, load the carry register with cin, clear nibble index idx and sum, and move to RUN.
REQ-018 On each RUN edge, the block SHALL write the CLA sum of a[idx], b[idx] and the carry register into sum nibble idx, load the CLA carry into the carry register, and increment idx.
REQ-019 On the RUN edge with idx == NIBBLES-1, the block SHALL load cout from the CLA carry and move to DONE.
REQ-020 Latency: res_valid SHALL rise exactly NIBBLES cycles after the acceptance edge.
REQ-021 In DONE, res_valid SHALL be 1, and sum and cout SHALL be held stable until res_valid && res_ready.
REQ-022 On the edge where res_valid && res_ready, the block SHALL clear res_valid and return to IDLE.
REQ-023 No new request SHALL be accepted on the same edge as a result completes; back-to-back throughput is one result per NIBBLES+2 cycles.
REQ-024 Changes on in_valid, a, b and cin outside IDLE SHALL have no effect.
REQ-025 Carry SHALL wrap without saturation: sum = (a+b+cin) mod 2^W, and cout = bit W of that addition.

Reset
REQ-026 Asserting rst_n low SHALL immediately force IDLE, idx=0, carry register=0, sum=0, cout=0, res_valid=0 and busy=0.
REQ-027 While rst_n is low, in_ready SHALL be 0; it SHALL rise to 1 once rst_n is high and the state is IDLE.
REQ-028 A reset asserted during RUN or DONE SHALL discard the operation, with no partial result visible afterwards.

Configuration
REQ-029 Macro CLA_SEQ_SUB_EN, when defined, SHALL add port sub (input, 1 bit), latched on acceptance.
REQ-030 With the macro defined and sub=1, the block SHALL use ~b, seed the carry register with 1 and ignore cin, so that sum = a-b mod 2^W and cout=1 means no borrow; with sub=0, behaviour SHALL be identical to the unconfigured block.
REQ-031 Without CLA_SEQ_SUB_EN, port sub SHALL not exist and the block SHALL perform addition only.

Verification (NIBBLES=4)
REQ-032 a=16'h1234, b=16'h4321, cin=0 -> res_valid 4 cycles after acceptance, sum=16'h5555, cout=0.
REQ-033 a=16'hFFFF, b=16'h0001, cin=0 -> sum=16'h0000, cout=1; a=16'h0FFF, b=16'h0000, cin=1 -> sum=16'h1000, cout=0.
REQ-034 res_ready held low 3 cycles in DONE -> sum and cout stable and in_ready=0 throughout; res_ready=1 -> IDLE on the next edge.
REQ-035 in_valid pulsed with a=16'hAAAA during RUN of 16'h0001+16'h0001 -> result 16'h0002, pulse ignored.
REQ-036 rst_n low after 2 RUN cycles -> sum=0, res_valid=0, IDLE; the next request 16'h0101+16'h0202 -> 16'h0303.
REQ-037 With CLA_SEQ_SUB_EN: sub=1, a=16'h1000, b=16'h0001 -> sum=16'h0FFF, cout=1; a=16'h0000, b=16'h0001 -> sum=16'hFFFF, cout=0.
